// File: rtl/cache_level_arbiter.sv
// Two-requester arbiter in front of the next cache level, with response routing by an order FIFO.
// Optional build macro: CACHE_ARB_FIXED_PRIORITY_EN (requester 0 always wins ties).
module cache_level_arbiter #(
  parameter int BW_ACCESS_ADDR   = 32,
  parameter int BW_CACHE_COMMAND = 2,
  parameter int BW_DATA_BLOCK    = 128,
  parameter int CMD_READ         = 1,
  parameter int N_OUTSTANDING    = 4
) (
  input  logic                        clock_i,
  input  logic                        resetn_i,
  input  logic                        req0_write_i,
  input  logic [BW_CACHE_COMMAND-1:0] req0_command_i,
  input  logic [BW_ACCESS_ADDR-1:0]   req0_addr_i,
  input  logic [BW_DATA_BLOCK-1:0]    req0_data_i,
  output logic                        req0_full_o,
  input  logic                        req1_write_i,
  input  logic [BW_CACHE_COMMAND-1:0] req1_command_i,
  input  logic [BW_ACCESS_ADDR-1:0]   req1_addr_i,
  input  logic [BW_DATA_BLOCK-1:0]    req1_data_i,
  output logic                        req1_full_o,
  output logic                        ext_write_o,
  output logic [BW_CACHE_COMMAND-1:0] ext_command_o,
  output logic [BW_ACCESS_ADDR-1:0]   ext_addr_o,
  output logic [BW_DATA_BLOCK-1:0]    ext_data_o,
  input  logic                        ext_full_i,
  input  logic                        ext_write_i,
  input  logic [BW_CACHE_COMMAND-1:0] ext_command_i,
  input  logic [BW_ACCESS_ADDR-1:0]   ext_addr_i,
  input  logic [BW_DATA_BLOCK-1:0]    ext_data_i,
  output logic                        ext_full_o,
  output logic                        resp0_write_o,
  output logic [BW_CACHE_COMMAND-1:0] resp0_command_o,
  output logic [BW_ACCESS_ADDR-1:0]   resp0_addr_o,
  output logic [BW_DATA_BLOCK-1:0]    resp0_data_o,
  input  logic                        resp0_full_i,
  output logic                        resp1_write_o,
  output logic [BW_CACHE_COMMAND-1:0] resp1_command_o,
  output logic [BW_ACCESS_ADDR-1:0]   resp1_addr_o,
  output logic [BW_DATA_BLOCK-1:0]    resp1_data_o,
  input  logic                        resp1_full_i,
  output logic                        error_o
);

  localparam int PW = $clog2(N_OUTSTANDING);
  localparam logic [BW_CACHE_COMMAND-1:0] RD = BW_CACHE_COMMAND'(CMD_READ);

  logic                        valid_q, valid_d;
  logic [BW_CACHE_COMMAND-1:0] cmd_q, cmd_d;
  logic [BW_ACCESS_ADDR-1:0]   addr_q, addr_d;
  logic [BW_DATA_BLOCK-1:0]    data_q, data_d;
  logic                        src_q, src_d;
  logic [N_OUTSTANDING-1:0]    ord_mem_q, ord_mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]                 count_q, count_d;
  logic                        error_q, error_d;

  logic retire, stage_free, fifo_full, fifo_empty;
  logic elig0, elig1, try0, try1, grant0, grant1, accept;
  logic [BW_CACHE_COMMAND-1:0] acc_cmd;
  logic push, pop, head;

  assign retire     = valid_q & ~ext_full_i;
  assign stage_free = ~valid_q | retire;
  assign fifo_full  = (count_q == (PW+1)'(N_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign elig0      = stage_free & ((req0_command_i != RD) | ~fifo_full);
  assign elig1      = stage_free & ((req1_command_i != RD) | ~fifo_full);
  assign try0       = req0_write_i & elig0;
  assign try1       = req1_write_i & elig1;

`ifdef CACHE_ARB_FIXED_PRIORITY_EN
  assign grant0 = try0;
  assign grant1 = try1 & ~try0;
`else
  logic last_grant_q, last_grant_d;
  // last_grant_q holds the id of the most recent winner; the other one wins a tie
  assign grant0 = try0 & (~try1 | last_grant_q);
  assign grant1 = try1 & (~try0 | ~last_grant_q);
  assign last_grant_d = accept ? grant1 : last_grant_q;
`endif

  assign accept  = grant0 | grant1;
  assign acc_cmd = grant1 ? req1_command_i : req0_command_i;
  assign push    = accept & (acc_cmd == RD);
  assign head    = ord_mem_q[rd_ptr_q];
  assign pop     = ext_write_i & ~fifo_empty;

  // Gating with resetn_i keeps requesters unblocked while the block is held in reset
  assign req0_full_o = resetn_i & (~elig0 | grant1);
  assign req1_full_o = resetn_i & (~elig1 | grant0);

  assign ext_write_o   = retire;
  assign ext_command_o = cmd_q;
  assign ext_addr_o    = addr_q;
  assign ext_data_o    = data_q;

  assign ext_full_o      = ~fifo_empty & (head ? resp1_full_i : resp0_full_i);
  assign resp0_write_o   = pop & ~head;
  assign resp1_write_o   = pop & head;
  assign resp0_command_o = ext_command_i;
  assign resp0_addr_o    = ext_addr_i;
  assign resp0_data_o    = ext_data_i;
  assign resp1_command_o = ext_command_i;
  assign resp1_addr_o    = ext_addr_i;
  assign resp1_data_o    = ext_data_i;
  assign error_o         = error_q;

  always_comb begin
    valid_d = accept | (valid_q & ~retire);
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    src_d   = src_q;
    if (accept) begin
      cmd_d  = acc_cmd;
      addr_d = grant1 ? req1_addr_i : req0_addr_i;
      data_d = grant1 ? req1_data_i : req0_data_i;
      src_d  = grant1;
    end
  end

  always_comb begin
    ord_mem_d = ord_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      ord_mem_d[wr_ptr_q] = grant1;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push & ~pop) count_d = count_q + 1'b1;
    else if (pop & ~push) count_d = count_q - 1'b1;
    error_d = error_q | (ext_write_i & fifo_empty);
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      valid_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

`ifndef CACHE_ARB_FIXED_PRIORITY_EN
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) last_grant_q <= 1'b1;
    else           last_grant_q <= last_grant_d;
  end
`endif

  // Payload and order-FIFO storage carry no reset; validity lives in the control flops
  always_ff @(posedge clock_i) begin
    cmd_q     <= cmd_d;
    addr_q    <= addr_d;
    data_q    <= data_d;
    src_q     <= src_d;
    ord_mem_q <= ord_mem_d;
  end

endmodule
